// File: rtl/pattern_checker.sv
// pattern_checker
//   Data-integrity checker for write-path loopback. Each accepted word is
//   compared with an internally generated expected sequence. The sequence is
//   counter, walking-one, LFSR or fixed. The block keeps saturating word,
//   word-error and bit-error counters and captures the first mismatch.
//   In auto-sync mode the generator is seeded from the first received word.
//
// Ports
//   clk, reset_n        clock, async active-low reset
//   start/stop          one-cycle pulses: begin (re-seed, clear) / end a run
//   clear_counters      one-cycle pulse: zero counters and first-error capture
//   mode, auto_sync, seed   run configuration, sampled only on start
//   data_in, data_valid word under test
//   running, locked     registered state decodes (SEEK|CHECK, CHECK)
//   error_flag          sticky first-mismatch flag
//   word_count, error_count, bit_error_count   saturating statistics
//   first_err_*         index/received/expected values of the first mismatch
module pattern_checker #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    CNT_WIDTH  = 32,
   parameter logic [DATA_WIDTH-1:0] LFSR_TAPS  = 32'h80200003
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  clear_counters,
   input  logic [1:0]            mode,
   input  logic                  auto_sync,
   input  logic [DATA_WIDTH-1:0] seed,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  data_valid,
   output logic                  running,
   output logic                  locked,
   output logic                  error_flag,
   output logic [CNT_WIDTH-1:0]  word_count,
   output logic [CNT_WIDTH-1:0]  error_count,
   output logic [CNT_WIDTH-1:0]  bit_error_count,
   output logic [CNT_WIDTH-1:0]  first_err_index,
   output logic [DATA_WIDTH-1:0] first_err_data,
   output logic [DATA_WIDTH-1:0] first_err_expected
);

   localparam int PW = $clog2(DATA_WIDTH + 1);
   // Sum width holds counter + popcount without overflow, for the clamp test.
   localparam int SW = ((CNT_WIDTH > PW) ? CNT_WIDTH : PW) + 1;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {IDLE, SEEK, CHECK} state_t;

   state_t                state;
   logic [1:0]            mode_q;
   logic [DATA_WIDTH-1:0] expected;

   logic [DATA_WIDTH-1:0] diff;
   logic [PW-1:0]         diff_bits;
   logic [SW-1:0]         bit_sum;
   logic [CNT_WIDTH-1:0]  bit_sat;

   function automatic logic [DATA_WIDTH-1:0] gen_next(input logic [1:0] m,
                                                      input logic [DATA_WIDTH-1:0] x);
      case (m)
         2'd0:    gen_next = x + DATA_WIDTH'(1);
         2'd1:    gen_next = {x[DATA_WIDTH-2:0], x[DATA_WIDTH-1]};
         2'd2:    gen_next = {x[DATA_WIDTH-2:0], ^(x & LFSR_TAPS)};
         default: gen_next = x;
      endcase
   endfunction

   function automatic logic [PW-1:0] popcnt(input logic [DATA_WIDTH-1:0] x);
      logic [PW-1:0] n;
      n = '0;
      for (int i = 0; i < DATA_WIDTH; i++) n = n + PW'(x[i]);
      return n;
   endfunction

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
      return (c == CNT_MAX) ? c : c + CNT_WIDTH'(1);
   endfunction

   always_comb begin
      diff      = data_in ^ expected;
      diff_bits = popcnt(diff);
      bit_sum   = SW'(bit_error_count) + SW'(diff_bits);
      // Clamp instead of wrapping when the addition would overflow.
      bit_sat   = (bit_sum > SW'(CNT_MAX)) ? CNT_MAX : bit_sum[CNT_WIDTH-1:0];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state              <= IDLE;
         mode_q             <= 2'd0;
         expected           <= '0;
         running            <= 1'b0;
         locked             <= 1'b0;
         error_flag         <= 1'b0;
         word_count         <= '0;
         error_count        <= '0;
         bit_error_count    <= '0;
         first_err_index    <= '0;
         first_err_data     <= '0;
         first_err_expected <= '0;
      end else if (start) begin
         // start overrides everything else, in any state.
         mode_q             <= mode;
         expected           <= seed;
         state              <= auto_sync ? SEEK : CHECK;
         running            <= 1'b1;
         locked             <= ~auto_sync;
         error_flag         <= 1'b0;
         word_count         <= '0;
         error_count        <= '0;
         bit_error_count    <= '0;
         first_err_index    <= '0;
         first_err_data     <= '0;
         first_err_expected <= '0;
      end else begin
         if (stop) begin
            state   <= IDLE;
            running <= 1'b0;
            locked  <= 1'b0;
         end else if (data_valid && state == SEEK) begin
            // Sync word only seeds the generator; it is not counted.
            expected <= gen_next(mode_q, data_in);
            state    <= CHECK;
            locked   <= 1'b1;
         end else if (data_valid && state == CHECK) begin
            expected   <= gen_next(mode_q, expected);
            word_count <= sat_inc(word_count);
            if (diff != '0) begin
               error_count     <= sat_inc(error_count);
               bit_error_count <= bit_sat;
               if (!error_flag) begin
                  error_flag         <= 1'b1;
                  first_err_index    <= word_count;
                  first_err_data     <= data_in;
                  first_err_expected <= expected;
               end
            end
         end
         // Later assignments win: a clear discards the statistics of a
         // word compared in the same cycle, the generator still advances.
         if (clear_counters) begin
            error_flag         <= 1'b0;
            word_count         <= '0;
            error_count        <= '0;
            bit_error_count    <= '0;
            first_err_index    <= '0;
            first_err_data     <= '0;
            first_err_expected <= '0;
         end
      end
   end

endmodule
